pid_serial_core: RTL and testbench

Parametrised, signed, saturating PID controller core computed serially over one shared multiplier. It accepts a setpoint/measurement sample with a valid/ready handshake. It produces one clamped control output per sample, plus a saturation flag. It sits behind the chip top-level, in place of the fixed 8-bit registered adder datapath, with pins mapped by the top wrapper.

---
 rtl/pid_serial_core.sv | 157 +++++++++++++++
 tb/tb_pid_serial_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pid_serial_core.sv
// pid_serial_core: serial signed saturating PID controller sharing one multiplier across P, I and D.
module pid_serial_core #(
    parameter int DATA_W  = 8,
    parameter int GAIN_W  = 8,
    parameter int FRAC_W  = 4,
    parameter int ACC_W   = 24,
    parameter int INT_LIM = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] measurement,
    input  logic [GAIN_W-1:0] kp,
    input  logic [GAIN_W-1:0] ki,
    input  logic [GAIN_W-1:0] kd,
    output logic              out_valid,
    output logic [DATA_W-1:0] y,
    output logic              y_sat
);
    localparam int IB = $clog2(INT_LIM + 1);
    localparam int IW = (IB > DATA_W + 1 ? IB : DATA_W + 1) + 2;
    localparam int OW = IW > DATA_W + 2 ? IW : DATA_W + 2;
    localparam int PW = OW + GAIN_W + 1;
    localparam int SW = (PW > ACC_W ? PW : ACC_W) + 1;
    localparam logic signed [SW-1:0] AMAX = SW'({(ACC_W-1){1'b1}});
    localparam logic signed [SW-1:0] AMIN = ~AMAX;
    localparam logic signed [IW-1:0] ILIM = IW'(INT_LIM);
    localparam logic signed [IW-1:0] NLIM = -ILIM;
    localparam logic signed [ACC_W-1:0] YMAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] YMIN = ~YMAX;

    typedef enum logic [2:0] {S_IDLE, S_ERR, S_P, S_I, S_D, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  sp_q, sp_d, meas_q, meas_d;
    logic        [GAIN_W-1:0]  kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic signed [DATA_W:0]    err_q, err_d, errp_q, errp_d, err_w;
    logic signed [DATA_W+1:0]  dif;
    logic signed [IW-1:0]      integ_q, integ_d, isum, iclamp;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_in, acc_sat, sh;
    logic signed [OW-1:0]      mul_a;
    logic signed [GAIN_W:0]    mul_b;
    logic signed [PW-1:0]      prod;
    logic signed [SW-1:0]      sum;
    logic        [DATA_W-1:0]  y_q, y_d;
    logic                      ysat_q, ysat_d, ov_q, ov_d;

    assign in_ready  = (state_q == S_IDLE) && ena;
    assign out_valid = ov_q;
    assign y         = y_q;
    assign y_sat     = ysat_q;

    // Datapath: the one shared multiplier picks its operand pair by state; P starts from an empty accumulator.
    always_comb begin
        err_w   = (DATA_W + 1)'(sp_q) - (DATA_W + 1)'(meas_q);
        dif     = (DATA_W + 2)'(err_q) - (DATA_W + 2)'(errp_q);
        isum    = integ_q + IW'(err_w);
        iclamp  = isum > ILIM ? ILIM : isum < NLIM ? NLIM : isum;
        mul_a   = state_q == S_P ? OW'(err_q) : state_q == S_I ? OW'(integ_q) : OW'(dif);
        mul_b   = {1'b0, state_q == S_P ? kp_q : state_q == S_I ? ki_q : kd_q};
        prod    = PW'(mul_a) * PW'(mul_b);
        acc_in  = state_q == S_P ? '0 : acc_q;
        sum     = SW'(acc_in) + SW'(prod);
        acc_sat = sum > AMAX ? {1'b0, {(ACC_W-1){1'b1}}} : sum < AMIN ? {1'b1, {(ACC_W-1){1'b0}}} : sum[ACC_W-1:0];
        sh      = acc_q >>> FRAC_W;
    end

    // Next state: everything holds unless enabled; clr wins over accept and over any in-flight sample.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        meas_d  = meas_q;
        kp_d    = kp_q;
        ki_d    = ki_q;
        kd_d    = kd_q;
        err_d   = err_q;
        errp_d  = errp_q;
        integ_d = integ_q;
        acc_d   = acc_q;
        y_d     = y_q;
        ysat_d  = ysat_q;
        ov_d    = ov_q;
        if (ena) begin
            ov_d = 1'b0;
            if (clr) begin
                state_d = S_IDLE;
                integ_d = '0;
                errp_d  = '0;
                acc_d   = '0;
            end else begin
                case (state_q)
                    S_IDLE: if (in_valid) begin
                        sp_d    = setpoint;
                        meas_d  = measurement;
                        kp_d    = kp;
                        ki_d    = ki;
                        kd_d    = kd;
                        state_d = S_ERR;
                    end
                    S_ERR: begin
                        err_d   = err_w;
                        integ_d = iclamp;
                        state_d = S_P;
                    end
                    S_P, S_I, S_D: begin
                        acc_d   = acc_sat;
                        state_d = state_q == S_P ? S_I : state_q == S_I ? S_D : S_OUT;
                    end
                    default: begin
                        y_d     = sh > YMAX ? YMAX[DATA_W-1:0] : sh < YMIN ? YMIN[DATA_W-1:0] : sh[DATA_W-1:0];
                        ysat_d  = sh > YMAX || sh < YMIN;
                        ov_d    = 1'b1;
                        errp_d  = err_q;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // State registers with asynchronous reset to the idle, zeroed condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            meas_q  <= '0;
            kp_q    <= '0;
            ki_q    <= '0;
            kd_q    <= '0;
            err_q   <= '0;
            errp_q  <= '0;
            integ_q <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            ysat_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            meas_q  <= meas_d;
            kp_q    <= kp_d;
            ki_q    <= ki_d;
            kd_q    <= kd_d;
            err_q   <= err_d;
            errp_q  <= errp_d;
            integ_q <= integ_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            ysat_q  <= ysat_d;
            ov_q    <= ov_d;
        end
    end
endmodule

// File: tb/tb_pid_serial_core.sv
// tb_pid_serial_core: directed self-checking bench for pid_serial_core.
module tb_pid_serial_core;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, clr = 1'b0, in_valid = 1'b0;
    logic in_ready, out_valid, y_sat;
    logic signed [7:0] setpoint = '0, measurement = '0, y;
    logic [7:0] kp = '0, ki = '0, kd = '0;
    int passed = 0, total = 0;

    pid_serial_core dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .setpoint(setpoint), .measurement(measurement), .kp(kp), .ki(ki), .kd(kd),
        .out_valid(out_valid), .y(y), .y_sat(y_sat)
    );

    always #5 clk = ~clk;

    task automatic drive(input int sp, input int meas, input int gp, input int gi, input int gd);
        setpoint = 8'(sp); measurement = 8'(meas); kp = 8'(gp); ki = 8'(gi); kd = 8'(gd);
    endtask

    task automatic send(input int sp, input int meas, input int gp, input int gi, input int gd,
                        output int yo, output int so, output int lat);
        int n = 0;
        @(negedge clk);
        drive(sp, meas, gp, gi, gd);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        yo = int'(y);
        so = int'(y_sat);
    endtask

    task automatic do_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (y !== 8'sd0) $display("FAIL reset_y: got %0d expected 0", y); else passed++;
        total++; if (y_sat !== 1'b0) $display("FAIL reset_ysat: got %0b expected 0", y_sat); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_ov: got %0b expected 0", out_valid); else passed++;
        @(negedge clk) rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_ov_after: got %0b expected 0", out_valid); else passed++;
    endtask

    task automatic test_p_d();
        int yv, sv, lat;
        send(50, 20, 16, 0, 0, yv, sv, lat);
        total++; if (lat !== 5) $display("FAIL pd_latency: got %0d expected 5", lat); else passed++;
        total++; if (yv !== 30) $display("FAIL pd_p_only_y: got %0d expected 30", yv); else passed++;
        total++; if (sv !== 0) $display("FAIL pd_p_only_sat: got %0d expected 0", sv); else passed++;
        do_clr();
        send(50, 20, 16, 0, 16, yv, sv, lat);
        total++; if (yv !== 60) $display("FAIL pd_first_deriv_y: got %0d expected 60", yv); else passed++;
        send(50, 20, 16, 0, 16, yv, sv, lat);
        total++; if (yv !== 30) $display("FAIL pd_zero_deriv_y: got %0d expected 30", yv); else passed++;
    endtask

    task automatic test_integral();
        int yv, sv, lat;
        do_clr();
        for (int i = 1; i <= 4; i++) begin
            send(10, 0, 0, 8, 0, yv, sv, lat);
            total++; if (yv !== 5 * i) $display("FAIL integ_step%0d: got %0d expected %0d", i, yv, 5 * i); else passed++;
        end
        do_clr();
        send(10, 0, 0, 8, 0, yv, sv, lat);
        total++; if (yv !== 5) $display("FAIL integ_after_clr: got %0d expected 5", yv); else passed++;
    endtask

    task automatic test_saturation();
        int yv, sv, lat;
        do_clr();
        send(127, 0, 255, 0, 0, yv, sv, lat);
        total++; if (yv !== 127) $display("FAIL sat_pos_y: got %0d expected 127", yv); else passed++;
        total++; if (sv !== 1) $display("FAIL sat_pos_flag: got %0d expected 1", sv); else passed++;
        send(-128, 127, 16, 0, 0, yv, sv, lat);
        total++; if (yv !== -128) $display("FAIL sat_neg_y: got %0d expected -128", yv); else passed++;
        total++; if (sv !== 1) $display("FAIL sat_neg_flag: got %0d expected 1", sv); else passed++;
    endtask

    task automatic test_windup();
        int yv, sv, lat, y7, y20;
        do_clr();
        y7 = 0;
        y20 = 0;
        for (int i = 1; i <= 20; i++) begin
            send(127, 0, 0, 1, 0, yv, sv, lat);
            if (i == 7) y7 = yv;
            if (i == 20) y20 = yv;
        end
        total++; if (y7 !== 55) $display("FAIL windup_s7: got %0d expected 55", y7); else passed++;
        total++; if (y20 !== 63) $display("FAIL windup_s20: got %0d expected 63", y20); else passed++;
        send(-127, 0, 0, 1, 0, yv, sv, lat);
        total++; if (yv !== 56) $display("FAIL windup_unwind: got %0d expected 56", yv); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc_cnt = 0, last = -1, bad = 0, first = -1, ov_cnt = 0;
        do_clr();
        @(negedge clk);
        drive(10, 0, 16, 0, 0);
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (in_ready) begin
                if (last >= 0 && c - last != 6) bad++;
                if (first < 0) first = c;
                last = c;
                acc_cnt++;
            end
            if (out_valid) ov_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (acc_cnt !== 5) $display("FAIL b2b_accepts: got %0d expected 5", acc_cnt); else passed++;
        total++; if (bad !== 0) $display("FAIL b2b_spacing: got %0d bad gaps expected 0", bad); else passed++;
        total++; if (first !== 0) $display("FAIL b2b_first: got %0d expected 0", first); else passed++;
        total++; if (ov_cnt !== 4) $display("FAIL b2b_results: got %0d expected 4", ov_cnt); else passed++;
    endtask

    task automatic test_ena();
        int lat = 0;
        do_clr();
        @(negedge clk);
        drive(50, 20, 16, 0, 0);
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(negedge clk) ena = (lat < 2 || lat >= 5);
            @(posedge clk); #1;
            lat++;
        end
        ena = 1'b1;
        total++; if (lat !== 8) $display("FAIL ena_latency: got %0d expected 8", lat); else passed++;
        total++; if (y !== 8'sd30) $display("FAIL ena_y: got %0d expected 30", y); else passed++;
        @(negedge clk) ena = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL ena_low_ready: got %0b expected 0", in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) $display("FAIL ena_ov_hold: got %0b expected 1", out_valid); else passed++;
        @(negedge clk) ena = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL ena_ov_drop: got %0b expected 0", out_valid); else passed++;
    endtask

    task automatic test_async_reset();
        int yv, sv, lat;
        do_clr();
        send(10, 0, 0, 8, 0, yv, sv, lat);
        total++; if (yv !== 5) $display("FAIL arst_pre_y: got %0d expected 5", yv); else passed++;
        @(negedge clk);
        drive(50, 20, 16, 8, 16);
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        total++; if (y !== 8'sd0) $display("FAIL arst_y: got %0d expected 0", y); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL arst_ov: got %0b expected 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL arst_ready: got %0b expected 1", in_ready); else passed++;
        @(negedge clk) rst_n = 1'b1;
        send(50, 20, 16, 8, 16, yv, sv, lat);
        total++; if (yv !== 75) $display("FAIL arst_fresh_y: got %0d expected 75", yv); else passed++;
        total++; if (lat !== 5) $display("FAIL arst_latency: got %0d expected 5", lat); else passed++;
    endtask

    initial begin
        test_reset();
        test_p_d();
        test_integral();
        test_saturation();
        test_windup();
        test_back_to_back();
        test_ena();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end
endmodule
